// File: rtl/lms_debug_ctrl.sv
// Host-link debug controller for the LMS filter.
// Decodes byte commands to load, read back and halt/run the adaptation.
module lms_debug_ctrl #(
  parameter int Nw      = 9,
  parameter int NBw     = 7,
  parameter int NBe     = 9,
  parameter int TIMEOUT = 1000
) (
  input  logic              clkA,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [Nw*NBw-1:0] coeff_in,
  input  logic [NBe-1:0]    e_in,
  output logic [Nw*NBw-1:0] o_coeffs,
  output logic              o_debug_load,
  output logic              o_enable
);

  localparam int QD = (Nw > 2) ? Nw : 2;
  localparam int QA = $clog2(QD);
  localparam int CW = $clog2(QD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;
  // Tap Nw/2 at 1.0 (5 fractional bits), matching the LMS reset state
  localparam logic [Nw*NBw-1:0] RST_C =
    (Nw*NBw)'(32) << (NBw * (Nw / 2));

  typedef enum logic [1:0] {
    IDLE, WR_COLLECT, WR_LOAD, TX_SEND
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       len_q, len_d;
  logic [TW-1:0]       to_q, to_d;
  logic [Nw*NBw-1:0]   shadow_q, shadow_d;
  logic [Nw*NBw-1:0]   coeffs_q, coeffs_d;
  logic                load_q, load_d;
  logic                en_q, en_d;
  logic [7:0]          txb_q [2**QA];
  logic [7:0]          txb_d [2**QA];
  logic [15:0]         e_ext;
  logic                rx_fire, tx_fire;

  function automatic logic [7:0] sext_tap(
    input logic [NBw-1:0] t
  );
    return {{(8-NBw){t[NBw-1]}}, t};
  endfunction

  assign e_ext    = {{(16-NBe){e_in[NBe-1]}}, e_in};
  assign rx_ready = (state_q == IDLE) ||
                    (state_q == WR_COLLECT);
  assign tx_valid = (state_q == TX_SEND);
  assign tx_data  = txb_q[cnt_q[QA-1:0]];
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  assign o_coeffs     = coeffs_q;
  assign o_debug_load = load_q;
  assign o_enable     = en_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    to_d     = to_q;
    shadow_d = shadow_q;
    coeffs_d = coeffs_q;
    load_d   = 1'b0;
    en_d     = en_q;
    txb_d    = txb_q;
    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d    = '0;
          len_d    = CW'(1);
          state_d  = TX_SEND;
          txb_d[0] = ACK;
          case (rx_data)
            8'h01: begin
              to_d    = '0;
              state_d = WR_COLLECT;
            end
            8'h02: begin
              for (int k = 0; k < Nw; k++)
                txb_d[QA'(k)] =
                  sext_tap(coeff_in[k*NBw +: NBw]);
              len_d = CW'(Nw);
            end
            8'h03: begin
              txb_d[0] = e_ext[7:0];
              txb_d[1] = e_ext[15:8];
              len_d    = CW'(2);
            end
            8'h04:   en_d = 1'b0;
            8'h05:   en_d = 1'b1;
            default: txb_d[0] = NACK;
          endcase
        end
      end
      WR_COLLECT: begin
        if (rx_fire) begin
          to_d = '0;
          shadow_d[int'(cnt_q)*NBw +: NBw] =
            rx_data[NBw-1:0];
          if (cnt_q == CW'(Nw - 1)) begin
            state_d = WR_LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          // Abort: shadow is simply never copied out
          txb_d[0] = NACK;
          len_d    = CW'(1);
          cnt_d    = '0;
          state_d  = TX_SEND;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      WR_LOAD: begin
        coeffs_d = shadow_q;
        load_d   = 1'b1;
        txb_d[0] = ACK;
        len_d    = CW'(1);
        cnt_d    = '0;
        state_d  = TX_SEND;
      end
      TX_SEND: begin
        if (tx_fire) begin
          if (cnt_q == len_q - CW'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkA) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      to_q     <= '0;
      shadow_q <= '0;
      coeffs_q <= RST_C;
      load_q   <= 1'b0;
      en_q     <= 1'b1;
      for (int i = 0; i < 2**QA; i++)
        txb_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      to_q     <= to_d;
      shadow_q <= shadow_d;
      coeffs_q <= coeffs_d;
      load_q   <= load_d;
      en_q     <= en_d;
      txb_q    <= txb_d;
    end
  end

endmodule

// File: tb/tb_lms_debug_ctrl.sv
// Randomized bench for lms_debug_ctrl against a byte-level
// command model of the host protocol.
module tb_lms_debug_ctrl;

  localparam int NW = 9;
  localparam int NB = 7;
  localparam int NE = 9;
  localparam int TO = 1000;

  logic          clkA = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [62:0]   coeff_in;
  logic [8:0]    e_in;
  logic [62:0]   o_coeffs;
  logic          o_debug_load;
  logic          o_enable;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;
  logic [62:0] load_val;

  int  m_tap [NW];
  bit  m_en;

  lms_debug_ctrl #(
    .Nw(NW), .NBw(NB), .NBe(NE), .TIMEOUT(TO)
  ) dut (
    .clkA(clkA), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .coeff_in(coeff_in), .e_in(e_in),
    .o_coeffs(o_coeffs),
    .o_debug_load(o_debug_load),
    .o_enable(o_enable)
  );

  always #5 clkA = ~clkA;

  always @(negedge clkA)
    if (o_debug_load === 1'b1) begin
      load_cnt++;
      load_val = o_coeffs;
    end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] model_coeffs();
    logic [62:0] p = '0;
    for (int k = 0; k < NW; k++)
      p = p | (63'(m_tap[k] & 127) << (k * NB));
    return p;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NW; k++) m_tap[k] = 0;
    m_tap[NW/2] = 32;
    m_en = 1'b1;
  endfunction

  // Spec-level protocol model: one command -> expected reply bytes
  function automatic void model_cmd(
    input logic [7:0] cmd, input logic [7:0] wd[$],
    output logic [7:0] exp[$]);
    int v;
    exp = {};
    case (cmd)
      8'h01: begin
        if (wd.size() == NW) begin
          for (int k = 0; k < NW; k++)
            m_tap[k] = wd[k] % 128;
          exp.push_back(8'hA5);
        end else exp.push_back(8'hEE);
      end
      8'h02:
        for (int k = 0; k < NW; k++) begin
          v = int'((coeff_in >> (k * NB)) & 63'd127);
          if (v >= 64) v -= 128;
          exp.push_back(8'(v & 255));
        end
      8'h03: begin
        v = int'(e_in);
        if (v >= 256) v -= 512;
        exp.push_back(8'(v & 255));
        exp.push_back(8'((v >>> 8) & 255));
      end
      8'h04: begin m_en = 1'b0; exp.push_back(8'hA5); end
      8'h05: begin m_en = 1'b1; exp.push_back(8'hA5); end
      default: exp.push_back(8'hEE);
    endcase
  endfunction

  task automatic send(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 100) begin
      @(negedge clkA);
      t++;
    end
    check("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(posedge clkA);
    @(negedge clkA);
    rx_valid = 1'b0;
  endtask

  task automatic recv(input int n, input bit stall,
                      output logic [7:0] got[$]);
    int t = 0;
    int stall_left;
    bit have = 0;
    logic [7:0] held = '0;
    stall_left = stall ? 5 : 0;
    got = {};
    while (got.size() < n && t < 3000) begin
      if (t > 0) @(negedge clkA);
      t++;
      if (have) begin
        check("tx_hold_valid", 64'(tx_valid), 64'd1);
        check("tx_hold_data", 64'(tx_data), 64'(held));
      end
      coeff_in = {$urandom, $urandom};
      e_in     = 9'($urandom);
      if (stall_left > 0 && got.size() == 4 && tx_valid) begin
        tx_ready = 1'b0;
        stall_left--;
      end else tx_ready = ($urandom_range(0, 3) != 0);
      have = 0;
      if (tx_valid === 1'b1) begin
        if (tx_ready) got.push_back(tx_data);
        else begin have = 1; held = tx_data; end
      end
    end
    @(negedge clkA);
    tx_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [7:0] cmd,
                     input logic [7:0] wd[$], input bit stall);
    logic [7:0] exp[$];
    logic [7:0] got[$];
    int l0 = load_cnt;
    int nload;
    model_cmd(cmd, wd, exp);
    nload = (cmd == 8'h01 && wd.size() == NW) ? 1 : 0;
    send(cmd);
    foreach (wd[i]) send(wd[i]);
    recv(exp.size(), stall, got);
    check({tag, "_nbytes"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < got.size())
        check({tag, "_byte"}, 64'(got[i]), 64'(exp[i]));
    check({tag, "_idle_rdy"}, 64'(rx_ready), 64'd1);
    check({tag, "_idle_txv"}, 64'(tx_valid), 64'd0);
    check({tag, "_loads"}, 64'(load_cnt - l0), 64'(nload));
    if (nload == 1)
      check({tag, "_load_val"}, 64'(load_val),
            64'(model_coeffs()));
    check({tag, "_coeffs"}, 64'(o_coeffs),
          64'(model_coeffs()));
    check({tag, "_enable"}, 64'(o_enable), 64'(m_en));
  endtask

  initial begin
    logic [7:0] wd[$];
    logic [7:0] none[$];
    logic [7:0] c;
    int r, l0;
    none = {};
    reset = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tx_ready = 1'b0; coeff_in = '0; e_in = '0;
    model_reset();
    repeat (3) @(negedge clkA);
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_load", 64'(o_debug_load), 64'd0);
    check("rst_enable", 64'(o_enable), 64'd1);
    check("rst_coeffs", 64'(o_coeffs), 64'(model_coeffs()));
    reset = 1'b1;
    @(negedge clkA);

    wd = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
          8'h06, 8'h07, 8'h08, 8'h09};
    txn("write_seq", 8'h01, wd, 1'b0);

    coeff_in = '0;
    for (int k = 0; k < NW; k++)
      coeff_in = coeff_in | (63'(k == 0 ? 8'h7F : 8'h10)
                             << (k * NB));
    txn("read_dir", 8'h02, none, 1'b1);

    e_in = 9'h1F0;
    txn("read_err_dir", 8'h03, none, 1'b0);

    wd = {8'h11, 8'hF2, 8'h33, 8'h44};
    txn("timeout", 8'h01, wd, 1'b0);

    txn("halt", 8'h04, none, 1'b0);
    txn("bad_cmd", 8'h7B, none, 1'b0);
    txn("run", 8'h05, none, 1'b0);

    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 5);
      wd = {};
      case (r)
        0: begin
          for (int k = 0; k < NW; k++)
            wd.push_back(8'($urandom));
          txn("rnd_write", 8'h01, wd, 1'b0);
        end
        1: begin
          coeff_in = {$urandom, $urandom};
          txn("rnd_read", 8'h02, none, it[0]);
        end
        2: begin
          e_in = 9'($urandom);
          txn("rnd_rderr", 8'h03, none, 1'b0);
        end
        3: txn("rnd_halt", 8'h04, none, 1'b0);
        4: txn("rnd_run", 8'h05, none, 1'b0);
        default: begin
          c = 8'($urandom_range(6, 255));
          txn("rnd_bad", c, none, 1'b0);
        end
      endcase
    end

    txn("halt2", 8'h04, none, 1'b0);
    l0 = load_cnt;
    send(8'h01);
    for (int k = 0; k < 5; k++) send(8'($urandom));
    reset = 1'b0;
    repeat (2) @(negedge clkA);
    reset = 1'b1;
    model_reset();
    check("rst2_coeffs", 64'(o_coeffs), 64'(model_coeffs()));
    check("rst2_enable", 64'(o_enable), 64'd1);
    check("rst2_rx_ready", 64'(rx_ready), 64'd1);
    tx_ready = 1'b1;
    r = 0;
    repeat (12) begin
      @(negedge clkA);
      if (tx_valid === 1'b1) r++;
    end
    tx_ready = 1'b0;
    check("rst2_no_tx", 64'(r), 64'd0);
    check("rst2_no_load", 64'(load_cnt - l0), 64'd0);
    coeff_in = {$urandom, $urandom};
    txn("post_rst_read", 8'h02, none, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
